// File: rtl/cla_pkg.sv
// Shared constants and parameter helpers for the pipelined lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  // Number of pipeline stages, which is also the latency in cycles.
  function automatic int unsigned nstage(input int unsigned width, input int unsigned gps);
    return width / (GROUP_W * gps);
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned gps);
    return (width >= GROUP_W) && ((width % GROUP_W) == 0) && (gps >= 1) &&
           (((width / GROUP_W) % gps) == 0);
  endfunction

endpackage

// File: rtl/cla4_cell.sv
// Combinational 4-bit carry-lookahead cell; c3 is the carry into bit 3 for overflow detection.
module cla4_cell
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               cout,
  output logic               c3
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic               c1;
  logic               c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g, p and cin.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves GPS 4-bit groups and
// registers its carry; operands are skewed forward and sums deskewed behind a global stall.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned SW     = GROUP_W * GPS;
  localparam int unsigned NSTAGE = nstage(WIDTH, GPS);

  if (!params_ok(WIDTH, GPS)) begin : g_bad_params
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and GPS must divide WIDTH/4");
  end

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  // Subtract folds into the add path: invert B and flip the carry-in.
  assign bx       = in_b ^ {WIDTH{in_sub}};
  assign c0       = in_cin ^ in_sub;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned DONE_W = (k + 1) * SW;
    localparam int unsigned REM_W  = WIDTH - DONE_W;

    logic [SW-1:0]     sa;
    logic [SW-1:0]     sb;
    logic [SW-1:0]     ssum;
    logic              scin;
    logic              sv;
    logic [DONE_W-1:0] s_d;
    logic [GPS:0]      gc;
    logic [GPS-1:0]    gc3;
    logic              unused_c3;
    logic              v_q;
    logic              c_q;
    logic [DONE_W-1:0] s_q;

    // Stage inputs: raw operands for stage 0, skewed registers from the previous stage otherwise.
    if (k == 0) begin : g_src
      assign sa   = in_a[SW-1:0];
      assign sb   = bx[SW-1:0];
      assign scin = c0;
      assign sv   = in_valid;
      assign s_d  = ssum;
    end else begin : g_src
      assign sa   = g_stage[k-1].g_rem.a_q[SW-1:0];
      assign sb   = g_stage[k-1].g_rem.b_q[SW-1:0];
      assign scin = g_stage[k-1].c_q;
      assign sv   = g_stage[k-1].v_q;
      assign s_d  = {ssum, g_stage[k-1].s_q};
    end

    assign gc[0] = scin;

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla4_cell u_cell (
        .a    (sa[j*GROUP_W +: GROUP_W]),
        .b    (sb[j*GROUP_W +: GROUP_W]),
        .cin  (gc[j]),
        .s    (ssum[j*GROUP_W +: GROUP_W]),
        .cout (gc[j+1]),
        .c3   (gc3[j])
      );
    end

    // Only the top group's c3 of the last stage matters.
    assign unused_c3 = ^gc3;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= sv;
        s_q <= s_d;
        c_q <= gc[GPS];
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_d;
      logic [REM_W-1:0] b_d;
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      if (k == 0) begin : g_up
        assign a_d = in_a[WIDTH-1:SW];
        assign b_d = bx[WIDTH-1:SW];
      end else begin : g_up
        assign a_d = g_stage[k-1].g_rem.a_q[WIDTH-k*SW-1:SW];
        assign b_d = g_stage[k-1].g_rem.b_q[WIDTH-k*SW-1:SW];
      end

      // Operand bits carry no control meaning, so they are not reset.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic msb_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          msb_q <= 1'b0;
        end else if (adv) begin
          msb_q <= gc3[GPS-1];
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGE-1].v_q;
  assign out_sum   = g_stage[NSTAGE-1].s_q;
  assign out_cout  = g_stage[NSTAGE-1].c_q;
  assign out_ovf   = g_stage[NSTAGE-1].g_last.msb_q ^ g_stage[NSTAGE-1].c_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Drives four configurations of cla_pipe_addsub from one stimulus stream and scores each
// against an arithmetic model with per-instance expected-result queues.
module tb_cla_pipe_addsub;

  localparam int unsigned NDUT = 4;
  localparam int unsigned QD   = 64;

  function automatic int unsigned cfg_w(input int unsigned i);
    case (i)
      0: return 16;
      1: return 4;
      2: return 32;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned cfg_g(input int unsigned i);
    case (i)
      0: return 1;
      1: return 1;
      2: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned cfg_lat(input int unsigned i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_cin;
  logic        in_sub;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic [NDUT-1:0] in_ready_v;
  logic [NDUT-1:0] out_valid_v;
  logic [NDUT-1:0] cout_v;
  logic [NDUT-1:0] ovf_v;
  logic [31:0]     sum_v [NDUT];

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    localparam int unsigned W = cfg_w(i);
    localparam int unsigned G = cfg_g(i);
    logic [W-1:0] s_w;
    logic rdy, ov, co, of;

    cla_pipe_addsub #(.WIDTH(W), .GPS(G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .in_a      (in_a[W-1:0]),
      .in_b      (in_b[W-1:0]),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (ov),
      .out_ready (out_ready),
      .out_sum   (s_w),
      .out_cout  (co),
      .out_ovf   (of)
    );

    assign sum_v[i]       = 32'(s_w);
    assign in_ready_v[i]  = rdy;
    assign out_valid_v[i] = ov;
    assign cout_v[i]      = co;
    assign ovf_v[i]       = of;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic plus the sign rule for overflow.
  function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input int unsigned cyc);
    logic [63:0] mask, am, bm, full;
    exp_t e;
    mask  = (64'd1 << w) - 64'd1;
    am    = {32'd0, a} & mask;
    bm    = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    full  = am + bm + 64'(cin ^ sub);
    e.s   = 32'(full & mask);
    e.c   = full[w];
    e.o   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    e.cyc = cyc;
    return e;
  endfunction

  exp_t        fifo [NDUT][QD];
  int unsigned wr [NDUT];
  int unsigned rd [NDUT];
  bit          stall_prev [NDUT];
  logic [31:0] held_sum [NDUT];
  bit          rst_prev;
  int unsigned cyc;
  int unsigned last_stall;
  bit          final_chk;
  bit          final_done;

  function automatic bit pending();
    for (int i = 0; i < NDUT; i++) if (wr[i] != rd[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: inputs change 1 time unit after posedge, so everything is stable here.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < NDUT; i++) begin
        wr[i] = 0;
        rd[i] = 0;
        stall_prev[i] = 1'b0;
      end
      rst_prev = 1'b1;
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        if (rst_prev) begin
          check($sformatf("d%0d rst out_valid", i), 64'(out_valid_v[i]), 64'd0);
          check($sformatf("d%0d rst sum", i), 64'(sum_v[i]), 64'd0);
          check($sformatf("d%0d rst cout", i), 64'(cout_v[i]), 64'd0);
          check($sformatf("d%0d rst ovf", i), 64'(ovf_v[i]), 64'd0);
          check($sformatf("d%0d rst in_ready", i), 64'(in_ready_v[i]), 64'd1);
        end
        check($sformatf("d%0d in_ready", i), 64'(in_ready_v[i]),
              64'(!out_valid_v[i] || out_ready));
        if (stall_prev[i]) begin
          check($sformatf("d%0d hold valid", i), 64'(out_valid_v[i]), 64'd1);
          check($sformatf("d%0d hold sum", i), 64'(sum_v[i]), 64'(held_sum[i]));
        end
        if (out_valid_v[i] && out_ready) begin
          check($sformatf("d%0d result expected", i), 64'(wr[i] != rd[i]), 64'd1);
          if (wr[i] != rd[i]) begin
            exp_t e;
            e = fifo[i][rd[i] % QD];
            rd[i]++;
            check($sformatf("d%0d sum", i), 64'(sum_v[i]), 64'(e.s));
            check($sformatf("d%0d cout", i), 64'(cout_v[i]), 64'(e.c));
            check($sformatf("d%0d ovf", i), 64'(ovf_v[i]), 64'(e.o));
            if (e.cyc > last_stall)
              check($sformatf("d%0d latency", i), 64'(cyc - e.cyc), 64'(cfg_lat(i)));
          end
        end
        if (in_valid && in_ready_v[i]) begin
          fifo[i][wr[i] % QD] = model(cfg_w(i), in_a, in_b, in_cin, in_sub, cyc);
          wr[i]++;
        end
        stall_prev[i] = out_valid_v[i] && !out_ready;
        held_sum[i]   = sum_v[i];
      end
      rst_prev = 1'b0;
      if (!out_ready) last_stall = cyc;
      if (final_chk && !final_done) begin
        for (int i = 0; i < NDUT; i++)
          check($sformatf("d%0d undrained", i), 64'(wr[i] - rd[i]), 64'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  task automatic rbeat();
    beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    beat(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    beat(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    beat(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    beat(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
    beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    beat(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
    idle(6);

    repeat (64) rbeat();
    idle(6);

    // Backpressure while full, with new beats still being offered.
    repeat (8) rbeat();
    for (int k = 0; k < 3; k++) begin
      rbeat();
      out_ready = 1'b0;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (8) rbeat();
    idle(6);

    // Random handshake on both sides.
    for (int k = 0; k < 150; k++) begin
      rbeat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    out_ready = 1'b1;
    idle(8);

    // Reset with beats in flight; nothing from before it may emerge.
    repeat (6) rbeat();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    idle(6);
    repeat (20) rbeat();
    idle(1);

    for (int n = 0; n < 200 && pending(); n++) @(posedge clk);
    final_chk = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
